// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with writeback bypass,
// inserts load-use bubbles, and handles flush/stall for the EX stage.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             ID_VALID,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic [4:0]       ID_RD,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [XLEN-1:0]  ID_DATA1,
  input  logic [XLEN-1:0]  ID_DATA2,
  input  logic [XLEN-1:0]  ID_IMM,
  input  logic [4:0]       ID_ALUOP,
  input  logic [CTRLW-1:0] ID_CTRL,
  input  logic             WB_WRITEENABLE,
  input  logic [4:0]       WB_WRITEADDRESS,
  input  logic [XLEN-1:0]  WB_WRITEDATA,
  output logic             LOAD_USE_STALL,
  output logic             EX_VALID,
  output logic [XLEN-1:0]  EX_PC,
  output logic [XLEN-1:0]  EX_IMM,
  output logic [XLEN-1:0]  EX_DATA1,
  output logic [XLEN-1:0]  EX_DATA2,
  output logic [4:0]       EX_RS1,
  output logic [4:0]       EX_RS2,
  output logic [4:0]       EX_RD,
  output logic [4:0]       EX_ALUOP,
  output logic [CTRLW-1:0] EX_CTRL,
  output logic [31:0]      BUBBLE_COUNT
);

  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]  ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]  ex_data1_q, ex_data1_d;
  logic [XLEN-1:0]  ex_data2_q, ex_data2_d;
  logic [4:0]       ex_rs1_q, ex_rs1_d;
  logic [4:0]       ex_rs2_q, ex_rs2_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [4:0]       ex_aluop_q, ex_aluop_d;
  logic [CTRLW-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [31:0]      bubble_count_q, bubble_count_d;

  logic             hazard;
  logic [XLEN-1:0]  op1, op2;

  // EX holds a load whose destination the ID instruction actually reads
  always_comb begin
    hazard = ex_valid_q & ex_ctrl_q[1] & (ex_rd_q != 5'd0) & ID_VALID &
             ((ID_USE_RS1 & (ID_RS1 == ex_rd_q)) |
              (ID_USE_RS2 & (ID_RS2 == ex_rd_q)));
  end

  assign LOAD_USE_STALL = hazard & ~FLUSH & ~RESET;

  // Register file writes on this same edge, so its read data is stale on a match
  always_comb begin
    op1 = ID_DATA1;
    op2 = ID_DATA2;
    if (ID_RS1 == 5'd0)
      op1 = '0;
    else if (WB_WRITEENABLE && (WB_WRITEADDRESS == ID_RS1))
      op1 = WB_WRITEDATA;
    if (ID_RS2 == 5'd0)
      op2 = '0;
    else if (WB_WRITEENABLE && (WB_WRITEADDRESS == ID_RS2))
      op2 = WB_WRITEDATA;
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_imm_d       = ex_imm_q;
    ex_data1_d     = ex_data1_q;
    ex_data2_d     = ex_data2_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_aluop_d     = ex_aluop_q;
    ex_ctrl_d      = ex_ctrl_q;
    bubble_count_d = bubble_count_q;
    if (RESET || FLUSH || (!STALL && hazard)) begin
      ex_valid_d = 1'b0;
      ex_pc_d    = '0;
      ex_imm_d   = '0;
      ex_data1_d = '0;
      ex_data2_d = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
      ex_rd_d    = '0;
      ex_aluop_d = '0;
      ex_ctrl_d  = '0;
      if (RESET)
        bubble_count_d = '0;
      else if (!FLUSH)
        bubble_count_d = bubble_count_q + 32'd1;
    end else if (!STALL) begin
      ex_valid_d = ID_VALID;
      ex_pc_d    = ID_PC;
      ex_imm_d   = ID_IMM;
      ex_data1_d = op1;
      ex_data2_d = op2;
      ex_rs1_d   = ID_RS1;
      ex_rs2_d   = ID_RS2;
      ex_rd_d    = ID_RD;
      ex_aluop_d = ID_ALUOP;
      ex_ctrl_d  = ID_VALID ? ID_CTRL : '0;
    end
  end

  always_ff @(posedge CLK) begin
    ex_valid_q     <= ex_valid_d;
    ex_pc_q        <= ex_pc_d;
    ex_imm_q       <= ex_imm_d;
    ex_data1_q     <= ex_data1_d;
    ex_data2_q     <= ex_data2_d;
    ex_rs1_q       <= ex_rs1_d;
    ex_rs2_q       <= ex_rs2_d;
    ex_rd_q        <= ex_rd_d;
    ex_aluop_q     <= ex_aluop_d;
    ex_ctrl_q      <= ex_ctrl_d;
    bubble_count_q <= bubble_count_d;
  end

  assign EX_VALID     = ex_valid_q;
  assign EX_PC        = ex_pc_q;
  assign EX_IMM       = ex_imm_q;
  assign EX_DATA1     = ex_data1_q;
  assign EX_DATA2     = ex_data2_q;
  assign EX_RS1       = ex_rs1_q;
  assign EX_RS2       = ex_rs2_q;
  assign EX_RD        = ex_rd_q;
  assign EX_ALUOP     = ex_aluop_q;
  assign EX_CTRL      = ex_ctrl_q;
  assign BUBBLE_COUNT = bubble_count_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/execute pipeline register for the RV32IM 5-stage core.
- Sits directly downstream of the register file. It captures the DATA1/DATA2 operands together with the decoded immediate, PC, register indices and control bits, and presents them to the EX stage.
- Owns three jobs: load-use hazard detection with bubble insertion, write-through bypass of the same-cycle writeback into the captured operands, and flush/stall handling.

Parameters:
XLEN, 32, datapath width
CTRLW, 8, control bus width (bit map given in Behaviour)

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
STALL  in  1  EX busy (e.g. M-ext divider); hold all EX outputs
FLUSH  in  1  branch/jump taken in EX; kill the instruction being captured
ID_VALID  in  1  ID holds a real instruction
ID_PC  in  XLEN  PC of the ID instruction
ID_RS1, ID_RS2, ID_RD  in  5 each  register indices
ID_USE_RS1, ID_USE_RS2  in  1 each  instruction actually reads rs1/rs2
ID_DATA1, ID_DATA2  in  XLEN  register file read data
ID_IMM  in  XLEN  sign-extended immediate
ID_ALUOP  in  5  ALU/MUL/DIV operation select
ID_CTRL  in  CTRLW  [0] REGWRITE [1] MEMREAD [2] MEMWRITE [3] MEMTOREG [4] BRANCH [5] JUMP [6] ALUSRC [7] PCSRC_A
WB_WRITEENABLE  in  1  writeback write strobe (same signal the register file sees)
WB_WRITEADDRESS  in  5  writeback destination
WB_WRITEDATA  in  XLEN  writeback data
LOAD_USE_STALL  out  1  combinational; PC and IF/ID must hold this cycle
EX_VALID  out  1  registered valid
EX_PC, EX_IMM, EX_DATA1, EX_DATA2  out  XLEN  registered
EX_RS1, EX_RS2, EX_RD  out  5  registered
EX_ALUOP  out  5  registered
EX_CTRL  out  CTRLW  registered
BUBBLE_COUNT  out  32  count of bubbles inserted by load-use detection

Behaviour:
- Reset: on a posedge with RESET=1, every EX_* output and BUBBLE_COUNT are cleared to 0 (EX_VALID=0, EX_CTRL=0). RESET overrides all other inputs. Reset applied mid-stall discards the held instruction.
- Hazard condition, combinational: EX_VALID & EX_CTRL[1] & (EX_RD!=0) & ((ID_USE_RS1 & ID_RS1==EX_RD) | (ID_USE_RS2 & ID_RS2==EX_RD)) & ID_VALID.
- LOAD_USE_STALL = hazard & ~FLUSH & ~RESET.
- Per-posedge update priority (RESET excluded):
  1. FLUSH=1: load bubble (EX_VALID=0, EX_CTRL=0, other fields don't-care but cleared to 0). No count.
  2. STALL=1: all EX_* hold their values. LOAD_USE_STALL is still driven per the formula. No count.
  3. hazard=1: load bubble; BUBBLE_COUNT += 1. The count wraps 0xFFFFFFFF -> 0.
  4. Otherwise, capture: EX_VALID=ID_VALID. EX_CTRL = ID_VALID ? ID_CTRL : 0. All other fields copy their ID_* counterparts. Operands are captured with the bypass and x0 rules below.
- Bypass: captured operand n = WB_WRITEDATA if WB_WRITEENABLE & WB_WRITEADDRESS!=0 & WB_WRITEADDRESS==ID_RSn; otherwise ID_DATAn.
  - Needed because the register file updates on the same edge, so its read data is stale.
  - Applied independently to rs1 and rs2; both may match the same write.
- x0: if ID_RSn==0, the captured operand is forced to 0 regardless of ID_DATAn or bypass.
- Latency: one cycle, ID inputs -> EX outputs.
- A load-use hazard resolves after exactly one bubble. Next cycle EX holds the bubble (EX_VALID=0), so hazard=0 and the ID instruction is captured; the loaded value then arrives via EX-stage forwarding.
- No state machine beyond the pipeline register and counter. The stall/bubble decision is stateless each cycle.

Test Plan:
- Reset: RESET=1 for 2 cycles with ID_VALID=1, ID_DATA1=0x12345678 -> EX_VALID=0, EX_DATA1=0, BUBBLE_COUNT=0. Next posedge after RESET=0 captures 0x12345678.
- Load-use: EX holds lw x5 (CTRL[1]=1, RD=5); ID add x6,x5,x7 with USE_RS1=1 -> LOAD_USE_STALL=1 and bubble inserted, BUBBLE_COUNT=1. Next cycle LOAD_USE_STALL=0 and the add is captured with EX_RD=6.
- No false hazard: load RD=0 with ID_RS1=0, or ID_USE_RS2=0 with ID_RS2=EX_RD -> LOAD_USE_STALL=0, no bubble, count unchanged.
- WB bypass: ID_RS1=3, ID_RS2=3, ID_DATA1=ID_DATA2=0x0, WB_WRITEENABLE=1, WB_WRITEADDRESS=3, WB_WRITEDATA=0xA5A5A5A5 -> EX_DATA1=EX_DATA2=0xA5A5A5A5. With WB_WRITEADDRESS=0, EX_DATA1=0; with ID_RS1=0 and ID_DATA1=0xFFFF0000, EX_DATA1=0.
- STALL hold: capture PC=0x100; assert STALL for 3 cycles while ID inputs change -> EX_PC stays 0x100 for all 3 cycles. Release STALL -> new ID PC captured on the next edge.
- FLUSH vs hazard: FLUSH=1 with a simultaneous load-use condition -> LOAD_USE_STALL=0, EX_VALID=0, BUBBLE_COUNT unchanged. FLUSH=1 with STALL=1 -> bubble loaded, not hold.
